// File: rtl/axi4l_wb_bridge.sv
// axi4l_wb_bridge: AXI4-Lite slave to Wishbone pipelined master, one transaction outstanding.
module axi4l_wb_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 255,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SEL_W-1:0]  wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic              wb_we_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_stall_i,
  input  logic [DATA_W-1:0] wb_dat_i
);
  localparam int CNT_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  typedef enum logic [2:0] {IDLE, WR, RD, BRESP, RRESP} state_t;
  state_t state;
  logic aw_hold, w_hold;
  logic [CNT_W-1:0] cnt;
  logic aw_fire, w_fire, ar_fire, tmo, ok;
  assign awready = state == IDLE && !aw_hold;
  assign wready = state == IDLE && !w_hold;
  // reads only start when no write is pending or arriving, so writes win ties
  assign arready = state == IDLE && !aw_hold && !w_hold && !awvalid && !wvalid;
  assign aw_fire = awvalid && awready;
  assign w_fire = wvalid && wready;
  assign ar_fire = arvalid && arready;
  assign tmo = TIMEOUT_CYC != 0 && cnt == LAST;
  assign ok = wb_ack_i && !wb_err_i;
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state <= IDLE;
      aw_hold <= 1'b0;
      w_hold <= 1'b0;
      cnt <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
      bvalid <= 1'b0;
      rvalid <= 1'b0;
      bresp <= 2'b00;
      rresp <= 2'b00;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_fire) begin
            wb_adr_o <= awaddr;
            aw_hold <= 1'b1;
          end
          if (w_fire) begin
            wb_dat_o <= wdata;
            wb_sel_o <= wstrb;
            w_hold <= 1'b1;
          end
          if ((aw_hold || aw_fire) && (w_hold || w_fire)) begin
            state <= WR;
            aw_hold <= 1'b0;
            w_hold <= 1'b0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o <= 1'b1;
            cnt <= '0;
          end else if (ar_fire) begin
            state <= RD;
            wb_adr_o <= araddr;
            wb_sel_o <= '1;
            wb_we_o <= 1'b0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            cnt <= '0;
          end
        end
        WR, RD: begin
          wb_stb_o <= wb_stb_o && wb_stall_i;
          cnt <= cnt + CNT_W'(1);
          if (wb_ack_i || wb_err_i || tmo) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o <= 1'b0;
            if (state == WR) begin
              bresp <= ok ? 2'b00 : 2'b10;
              bvalid <= 1'b1;
              state <= BRESP;
            end else begin
              rresp <= ok ? 2'b00 : 2'b10;
              rdata <= ok ? wb_dat_i : '0;
              rvalid <= 1'b1;
              state <= RRESP;
            end
          end
        end
        BRESP: if (bready) begin
          bvalid <= 1'b0;
          state <= IDLE;
        end
        RRESP: if (rready) begin
          rvalid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4l_wb_bridge.sv
// tb_axi4l_wb_bridge: scoreboarded random and directed checks of the AXI4-Lite to Wishbone bridge.
module tb_axi4l_wb_bridge;
  localparam int TO = 8;
  logic aclk = 1'b0, areset_n = 1'b0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic awready, wready, arready, bvalid, rvalid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0] wb_sel_o;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;
  logic [31:0] wb_dat_i = '0;
  always #5 aclk = ~aclk;
  axi4l_wb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i)
  );
  // kind: 0 ack, 1 err, 2 never answered (timeout), 3 never answered (aborted by reset)
  typedef struct {
    bit we;
    logic [31:0] adr;
    logic [3:0] sel;
    logic [31:0] dat;
    int stall;
    int delay;
    int kind;
    logic [31:0] rd;
  } plan_t;
  plan_t plan_q[$];
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  int checks = 0, errors = 0, rlow = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int st, input int dl, input int k);
    plan_t p;
    p = '{1'b1, a, s, d, st, dl, k, 32'h0};
    plan_q.push_back(p);
    bq.push_back(k == 0 ? 2'b00 : 2'b10);
    awaddr = a;
    wdata = d;
    wstrb = s;
  endtask
  task automatic push_r(input logic [31:0] a, input logic [31:0] d, input int st, input int dl,
                        input int k);
    plan_t p;
    p = '{1'b0, a, 4'hF, 32'h0, st, dl, k, d};
    plan_q.push_back(p);
    if (k != 3) rq.push_back(k == 0 ? {2'b00, d} : {2'b10, 32'h0});
    araddr = a;
  endtask
  task automatic drive(input bit dw, input bit dr, input int awd, input int wd, input int ard);
    bit aw_done, w_done, ar_done;
    int k;
    aw_done = !dw;
    w_done = !dw;
    ar_done = !dr;
    k = 0;
    while (!(aw_done && w_done && ar_done) && k < 150) begin
      awvalid = !aw_done && k >= awd;
      wvalid = !w_done && k >= wd;
      arvalid = !ar_done && k >= ard;
      @(negedge aclk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      if (arvalid && arready) ar_done = 1;
      @(posedge aclk);
      #1;
      k++;
    end
    awvalid = 0;
    wvalid = 0;
    arvalid = 0;
    chk("addr_data_accepted", 64'(aw_done && w_done && ar_done), 64'(1));
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((bq.size() + rq.size() + plan_q.size()) != 0 && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
    end
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    chk("scoreboard_drained", 64'(bq.size() + rq.size() + plan_q.size()), 64'(0));
  endtask
  task automatic run_txn();
    plan_t p;
    int n, g;
    if (plan_q.size() == 0) begin
      chk("wb_access_expected", 64'(plan_q.size()), 64'(1));
      return;
    end
    p = plan_q.pop_front();
    chk("wb_stb_first", 64'(wb_stb_o), 64'(1));
    chk("wb_we", 64'(wb_we_o), 64'(p.we));
    chk("wb_adr", 64'(wb_adr_o), 64'(p.adr));
    chk("wb_sel", 64'(wb_sel_o), 64'(p.sel));
    if (p.we) chk("wb_dat", 64'(wb_dat_o), 64'(p.dat));
    n = 1;
    for (int i = 0; i < p.stall; i++) begin
      wb_stall_i = 1;
      @(posedge aclk);
      #1;
      n++;
      chk("wb_stb_stalled", 64'(wb_stb_o), 64'(1));
    end
    wb_stall_i = 0;
    if (p.kind < 2) begin
      for (int i = 0; i < p.delay; i++) begin
        @(posedge aclk);
        #1;
        chk("wb_stb_dropped", 64'(wb_stb_o), 64'(0));
        chk("wb_cyc_held", 64'(wb_cyc_o), 64'(1));
      end
      wb_ack_i = p.kind == 0 ? 1'b1 : 1'($urandom % 2);
      wb_err_i = p.kind == 1;
      wb_dat_i = p.kind == 0 ? p.rd : $urandom;
      @(posedge aclk);
      #1;
      wb_ack_i = 0;
      wb_err_i = 0;
      wb_dat_i = $urandom;
      chk("wb_cyc_release", 64'(wb_cyc_o), 64'(0));
      chk("resp_next_cycle", 64'(p.we ? bvalid : rvalid), 64'(1));
    end else begin
      g = 0;
      while (wb_cyc_o && g < 40) begin
        @(posedge aclk);
        #1;
        if (wb_cyc_o) n++;
        g++;
      end
      if (p.kind == 2) begin
        chk("timeout_cycles", 64'(n), 64'(TO));
        chk("resp_after_timeout", 64'(p.we ? bvalid : rvalid), 64'(1));
      end
      wb_ack_i = 1;
      wb_dat_i = $urandom;
      @(posedge aclk);
      #1;
      wb_ack_i = 0;
    end
  endtask
  initial forever begin
    @(posedge aclk);
    #1;
    wb_dat_i = $urandom;
    if (wb_cyc_o && areset_n) run_txn();
  end
  initial forever begin
    @(posedge aclk);
    #1;
    bready = ($urandom % 3) != 0;
    if (rvalid && rlow > 0) begin
      rready = 0;
      rlow--;
    end else rready = ($urandom % 3) != 0;
  end
  logic pbv = 1'b0, pbr = 1'b0, prv = 1'b0, prr = 1'b0;
  logic [1:0] pbresp = '0;
  logic [33:0] pr = '0;
  always @(negedge aclk) begin
    if (!areset_n) begin
      pbv <= 1'b0;
      prv <= 1'b0;
    end else begin
      if (pbv && !pbr) begin
        chk("bvalid_hold", 64'(bvalid), 64'(1));
        chk("bresp_stable", 64'(bresp), 64'(pbresp));
      end
      if (prv && !prr) begin
        chk("rvalid_hold", 64'(rvalid), 64'(1));
        chk("rdata_stable", 64'({rresp, rdata}), 64'(pr));
      end
      if (bvalid && bready) begin
        chk("b_expected", 64'(bq.size() > 0), 64'(1));
        if (bq.size() > 0) chk("bresp", 64'(bresp), 64'(bq.pop_front()));
      end
      if (rvalid && rready) begin
        chk("r_expected", 64'(rq.size() > 0), 64'(1));
        if (rq.size() > 0) chk("rresp_rdata", 64'({rresp, rdata}), 64'(rq.pop_front()));
      end
      if (awvalid || wvalid) chk("arready_blocked", 64'(arready), 64'(0));
      pbv <= bvalid;
      pbr <= bready;
      pbresp <= bresp;
      prv <= rvalid;
      prr <= rready;
      pr <= {rresp, rdata};
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_cyc_stb_we", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'(0));
    chk("rst_valids", 64'({bvalid, rvalid}), 64'(0));
    chk("rst_resps", 64'({bresp, rresp}), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_adr_dat_sel", 64'({wb_adr_o, wb_sel_o} | 36'(wb_dat_o)), 64'(0));
    areset_n = 1;
    @(posedge aclk);
    #1;
    chk("idle_readies", 64'({awready, wready, arready}), 64'(3'b111));
    push_w(32'h10, 32'hCAFEBABE, 4'hF, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drain();
    push_w(32'h20, 32'h0BADF00D, 4'h3, 3, 0, 0);
    drive(1, 0, 2, 0, 0);
    drain();
    rlow = 3;
    push_r(32'h24, 32'h12345678, 0, 5, 0);
    drive(0, 1, 0, 0, 0);
    drain();
    push_r(32'h28, 32'hDEADBEEF, 1, 2, 1);
    drive(0, 1, 0, 0, 0);
    drain();
    push_w(32'h2C, 32'h55AA55AA, 4'hC, 0, 1, 1);
    drive(1, 0, 0, 1, 0);
    drain();
    push_w(32'h30, 32'h11112222, 4'hF, 2, 0, 2);
    drive(1, 0, 0, 0, 0);
    drain();
    push_r(32'h34, 32'h0, 0, 0, 2);
    drive(0, 1, 0, 0, 0);
    drain();
    push_w(32'h40, 32'hA5A5A5A5, 4'h9, 1, 1, 0);
    push_r(32'h44, 32'h87654321, 0, 2, 0);
    drive(1, 1, 0, 0, 0);
    drain();
    push_r(32'h48, 32'h0, 0, 0, 3);
    drive(0, 1, 0, 0, 0);
    repeat (2) @(posedge aclk);
    #1;
    areset_n = 0;
    @(posedge aclk);
    #1;
    chk("reset_abort_cyc", 64'(wb_cyc_o), 64'(0));
    chk("reset_abort_rvalid", 64'(rvalid), 64'(0));
    areset_n = 1;
    repeat (12) @(posedge aclk);
    #1;
    chk("no_rvalid_after_reset", 64'(rvalid), 64'(0));
    drain();
    for (int t = 0; t < 40; t++) begin
      int k, st, dl;
      logic [31:0] a, d;
      k = ($urandom % 8 == 0) ? 2 : (($urandom % 5 == 0) ? 1 : 0);
      st = int'($urandom % 4);
      dl = int'($urandom % 4);
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom;
      if ($urandom % 3 != 0) begin
        push_w(a, d, 4'($urandom), st, dl, k);
        drive(1, 0, int'($urandom % 3), int'($urandom % 3), 0);
      end else begin
        push_r(a, d, st, dl, k);
        drive(0, 1, 0, 0, int'($urandom % 3));
      end
      drain();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
